hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: MULDIV_CYCLES, default 32, EX-stage mult/div latency in cycles (legal range 2..63).
REQ-002 One clock; reset is asynchronous and active-low. Ports: clk_i in 1 rising-edge clock; reset_ni in 1 async active-low reset.
REQ-003 rs_id5, rt_id5  in  5 each  source register fields of the instruction in ID.
REQ-004 rs_oe5, rt_oe5  in  5 each  source register fields of the instruction in EX.
REQ-005 write_reg_oe5, write_reg_om5, write_reg_ow5  in  5 each  destination register in EX, MEM and WB.
REQ-006 enable_wreg_oe, enable_wreg_om, enable_wreg_ow  in  1 each  register-write enable in EX, MEM and WB.
REQ-007 mem_to_reg_oe, mem_to_reg_om  in  1 each  load instruction in EX or MEM.
REQ-008 branch_id  in  1  ID holds a branch; pc_src_id in 1 branch resolved taken in ID.
REQ-009 muldiv_start_oe  in  1  mult/div issued in EX this cycle; muldiv_id in 1 ID holds mult/div; mfhilo_id in 1 ID reads HI/LO.
REQ-010 stall_if, stall_id  out  1 each  hold the PC and the IF/ID register.
REQ-011 flush_oe  out  1  clear the ID/EX register (bubble insert); flush_id out 1 clear the IF/ID register.
REQ-012 forward_a_oe2, forward_b_oe2  out  2 each  EX ALU operand select: 00 register file, 10 MEM result, 01 WB result.
REQ-013 forward_a_id, forward_b_id  out  1 each  ID branch comparator takes the MEM result.
REQ-014 muldiv_busy  out  1  mult/div unit occupied.

Function
REQ-015 Register 0 SHALL never be forwarded and SHALL never cause a stall.
REQ-016 forward_a_oe2 SHALL be 10 when enable_wreg_om and write_reg_om5==rs_oe5; otherwise 01 when enable_wreg_ow and write_reg_ow5==rs_oe5; otherwise 00. MEM has priority over WB. forward_b_oe2 follows the same rule using rt_oe5.
REQ-017 forward_a_id SHALL be 1 when enable_wreg_om and write_reg_om5==rs_id5. forward_b_id follows the same rule using rt_id5.
REQ-018 lw_stall SHALL be 1 when mem_to_reg_oe and write_reg_oe5 equals rs_id5 or rt_id5.
REQ-019 br_stall SHALL be 1 when branch_id and either condition holds: (a) enable_wreg_oe and write_reg_oe5 equals rs_id5 or rt_id5; (b) mem_to_reg_om and write_reg_om5 equals rs_id5 or rt_id5.
REQ-020 The mult/div FSM SHALL have two states, IDLE and BUSY, and a down-counter of width $clog2(MULDIV_CYCLES).
REQ-021 IDLE to BUSY: muldiv_start_oe sampled high on a clock edge; the counter loads MULDIV_CYCLES-1.
REQ-022 BUSY: the counter decrements each cycle; the FSM returns to IDLE on the edge where the counter is 0. BUSY therefore lasts exactly MULDIV_CYCLES cycles.
REQ-023 muldiv_start_oe while BUSY SHALL be ignored (no reload); this case is illegal by construction (see REQ-024).
REQ-024 md_stall SHALL be 1 when the state is BUSY and (mfhilo_id or muldiv_id).
REQ-025 muldiv_busy SHALL be 1 exactly in BUSY.
REQ-026 stall_if, stall_id and flush_oe SHALL each equal lw_stall | br_stall | md_stall, in the same cycle (combinational, zero latency).
REQ-027 flush_id SHALL be pc_src_id & ~stall_id; a taken branch under stall SHALL NOT flush.
REQ-028 All forwarding and stall outputs SHALL be combinational from the current inputs and state; only the FSM and counter are registered.

Reset
REQ-029 reset_ni low SHALL asynchronously force the IDLE state and counter 0, at any time including mid-BUSY.
REQ-030 During reset: muldiv_busy=0, md_stall=0; the remaining outputs follow REQ-016 to REQ-027 with md_stall=0.
REQ-031 After reset_ni rises, the first muldiv_start_oe sampled on a clock edge SHALL start a full MULDIV_CYCLES busy period.

Verification
REQ-032 EX add writes r5 (enable_wreg_om=1, write_reg_om5=5) and WB also writes r5; rs_oe5=5 -> forward_a_oe2=10. Same setup with write_reg_om5=0 -> forward_a_oe2=00, no stall.
REQ-033 EX load writes r3 (mem_to_reg_oe=1, write_reg_oe5=3); rt_id5=3 -> stall_if=stall_id=flush_oe=1 for one cycle; next cycle, with the load now in MEM and the forwarding inputs updated, forward_b_oe2=10 and stalls are 0.
REQ-034 branch_id=1 with rs_id5=4 and an EX ALU op writing r4 -> stall 1 cycle; with pc_src_id=1 in that cycle flush_id=0; in the following cycle flush_id=1 and forward_a_id=1.
REQ-035 MULDIV_CYCLES=4: muldiv_start_oe pulse at edge N -> muldiv_busy=1 for edges N+1..N+4; mfhilo_id held high -> stall_if=1 while BUSY, then 0 on the cycle busy drops.
REQ-036 BUSY with counter 2: assert reset_ni=0 between clock edges -> muldiv_busy=0 immediately and stall_if drops; after release, no stall occurs until a new muldiv_start_oe.

Source files
------------

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Hazard detection and forwarding control for a 5-stage pipeline with a
//   multi-cycle mult/div unit in EX.
//
//   Forwarding:
//     forward_a_oe2/forward_b_oe2 : EX operand select
//                                   (00 regfile, 10 MEM result, 01 WB result)
//     forward_a_id/forward_b_id   : ID branch comparator takes the MEM result
//   Stalls:
//     stall_if, stall_id : hold PC and IF/ID
//     flush_oe           : bubble into ID/EX
//     flush_id           : squash IF/ID on a taken branch, unless stalled
//   Mult/div occupancy:
//     muldiv_busy        : unit busy for exactly MULDIV_CYCLES cycles after
//                          muldiv_start_oe is sampled
//
//   Inputs:
//     clk_i, reset_ni                              clock, async active-low reset
//     rs_id5, rt_id5                               ID source registers
//     rs_oe5, rt_oe5                               EX source registers
//     write_reg_oe5/om5/ow5, enable_wreg_oe/om/ow  EX/MEM/WB destinations
//     mem_to_reg_oe, mem_to_reg_om                 load in EX / MEM
//     branch_id, pc_src_id                         branch in ID / taken
//     muldiv_start_oe, muldiv_id, mfhilo_id        mult/div control
//
//   Only the mult/div FSM state and its counter are registered; every other
//   output is combinational from the current inputs and that state.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int unsigned MULDIV_CYCLES = 32
) (
  input  logic       clk_i,
  input  logic       reset_ni,

  input  logic [4:0] rs_id5,
  input  logic [4:0] rt_id5,
  input  logic [4:0] rs_oe5,
  input  logic [4:0] rt_oe5,

  input  logic [4:0] write_reg_oe5,
  input  logic [4:0] write_reg_om5,
  input  logic [4:0] write_reg_ow5,
  input  logic       enable_wreg_oe,
  input  logic       enable_wreg_om,
  input  logic       enable_wreg_ow,

  input  logic       mem_to_reg_oe,
  input  logic       mem_to_reg_om,

  input  logic       branch_id,
  input  logic       pc_src_id,

  input  logic       muldiv_start_oe,
  input  logic       muldiv_id,
  input  logic       mfhilo_id,

  output logic       stall_if,
  output logic       stall_id,
  output logic       flush_oe,
  output logic       flush_id,

  output logic [1:0] forward_a_oe2,
  output logic [1:0] forward_b_oe2,
  output logic       forward_a_id,
  output logic       forward_b_id,

  output logic       muldiv_busy
);

  localparam int unsigned CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // ---------------------------------------------------------------------------
  // Qualified writers: a stage only counts as a producer when it writes a
  // register other than r0 (r0 is hardwired zero, never forwarded or waited on).
  // ---------------------------------------------------------------------------
  logic w_wr_oe_nz;
  logic w_wr_om_nz;
  logic w_wr_ow_nz;

  assign w_wr_oe_nz = (write_reg_oe5 != 5'd0);
  assign w_wr_om_nz = (write_reg_om5 != 5'd0);
  assign w_wr_ow_nz = (write_reg_ow5 != 5'd0);

  logic w_om_writes;
  logic w_ow_writes;

  assign w_om_writes = enable_wreg_om & w_wr_om_nz;
  assign w_ow_writes = enable_wreg_ow & w_wr_ow_nz;

  // ---------------------------------------------------------------------------
  // EX operand forwarding: MEM result is newer than WB, so it wins.
  // ---------------------------------------------------------------------------
  logic w_fa_mem;
  logic w_fa_wb;
  logic w_fb_mem;
  logic w_fb_wb;

  assign w_fa_mem = w_om_writes & (write_reg_om5 == rs_oe5);
  assign w_fa_wb  = w_ow_writes & (write_reg_ow5 == rs_oe5);
  assign w_fb_mem = w_om_writes & (write_reg_om5 == rt_oe5);
  assign w_fb_wb  = w_ow_writes & (write_reg_ow5 == rt_oe5);

  always_comb begin
    forward_a_oe2 = FWD_RF;
    forward_b_oe2 = FWD_RF;
    if (w_fa_mem) begin
      forward_a_oe2 = FWD_MEM;
    end else if (w_fa_wb) begin
      forward_a_oe2 = FWD_WB;
    end
    if (w_fb_mem) begin
      forward_b_oe2 = FWD_MEM;
    end else if (w_fb_wb) begin
      forward_b_oe2 = FWD_WB;
    end
  end

  // ID branch comparator operand forwarding from MEM.
  assign forward_a_id = w_om_writes & (write_reg_om5 == rs_id5);
  assign forward_b_id = w_om_writes & (write_reg_om5 == rt_id5);

  // ---------------------------------------------------------------------------
  // Stall sources
  // ---------------------------------------------------------------------------
  logic w_oe_hits_id;
  logic w_om_hits_id;

  assign w_oe_hits_id = w_wr_oe_nz &
                        ((write_reg_oe5 == rs_id5) | (write_reg_oe5 == rt_id5));
  assign w_om_hits_id = w_wr_om_nz &
                        ((write_reg_om5 == rs_id5) | (write_reg_om5 == rt_id5));

  logic w_lw_stall;
  logic w_br_stall;
  logic w_md_stall;
  logic w_stall;

  // Load in EX feeding ID: data is not available until after MEM.
  assign w_lw_stall = mem_to_reg_oe & w_oe_hits_id;

  // Branch resolves in ID: wait for any ALU result still in EX, and for a
  // load result still in MEM.
  assign w_br_stall = branch_id &
                      ((enable_wreg_oe & w_oe_hits_id) |
                       (mem_to_reg_om  & w_om_hits_id));

  // ---------------------------------------------------------------------------
  // Mult/div occupancy FSM (state register + next-state logic)
  // ---------------------------------------------------------------------------
  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [0:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A start seen while BUSY is dropped; the counter is never reloaded mid-run.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (muldiv_start_oe) begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      ST_BUSY: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign muldiv_busy = (r_state == ST_BUSY);

  // Any access to HI/LO or a new mult/div must wait for the unit.
  assign w_md_stall = muldiv_busy & (mfhilo_id | muldiv_id);

  // ---------------------------------------------------------------------------
  // Pipeline control outputs
  // ---------------------------------------------------------------------------
  assign w_stall  = w_lw_stall | w_br_stall | w_md_stall;

  assign stall_if = w_stall;
  assign stall_id = w_stall;
  assign flush_oe = w_stall;

  // A taken branch held in ID by a stall is re-evaluated next cycle.
  assign flush_id = pc_src_id & ~w_stall;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int unsigned MD = 4;

  logic       clk_i;
  logic       reset_ni;
  logic [4:0] rs_id5, rt_id5, rs_oe5, rt_oe5;
  logic [4:0] write_reg_oe5, write_reg_om5, write_reg_ow5;
  logic       enable_wreg_oe, enable_wreg_om, enable_wreg_ow;
  logic       mem_to_reg_oe, mem_to_reg_om;
  logic       branch_id, pc_src_id;
  logic       muldiv_start_oe, muldiv_id, mfhilo_id;
  logic       stall_if, stall_id, flush_oe, flush_id;
  logic [1:0] forward_a_oe2, forward_b_oe2;
  logic       forward_a_id, forward_b_id;
  logic       muldiv_busy;

  int checks;
  int failures;

  hazard_ctrl #(.MULDIV_CYCLES(MD)) dut (
    .clk_i          (clk_i),
    .reset_ni       (reset_ni),
    .rs_id5         (rs_id5),
    .rt_id5         (rt_id5),
    .rs_oe5         (rs_oe5),
    .rt_oe5         (rt_oe5),
    .write_reg_oe5  (write_reg_oe5),
    .write_reg_om5  (write_reg_om5),
    .write_reg_ow5  (write_reg_ow5),
    .enable_wreg_oe (enable_wreg_oe),
    .enable_wreg_om (enable_wreg_om),
    .enable_wreg_ow (enable_wreg_ow),
    .mem_to_reg_oe  (mem_to_reg_oe),
    .mem_to_reg_om  (mem_to_reg_om),
    .branch_id      (branch_id),
    .pc_src_id      (pc_src_id),
    .muldiv_start_oe(muldiv_start_oe),
    .muldiv_id      (muldiv_id),
    .mfhilo_id      (mfhilo_id),
    .stall_if       (stall_if),
    .stall_id       (stall_id),
    .flush_oe       (flush_oe),
    .flush_id       (flush_id),
    .forward_a_oe2  (forward_a_oe2),
    .forward_b_oe2  (forward_b_oe2),
    .forward_a_id   (forward_a_id),
    .forward_b_id   (forward_b_id),
    .muldiv_busy    (muldiv_busy)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    string      name;
    logic [4:0] rs_id, rt_id, rs_oe, rt_oe, wr_oe, wr_om, wr_ow;
    logic       en_oe, en_om, en_ow, m2r_oe, m2r_om, br, pcsrc;
    logic [1:0] exp_fa, exp_fb;
    logic       exp_fida, exp_fidb, exp_stall, exp_flush_id;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    rs_id5 = '0; rt_id5 = '0; rs_oe5 = '0; rt_oe5 = '0;
    write_reg_oe5 = '0; write_reg_om5 = '0; write_reg_ow5 = '0;
    enable_wreg_oe = 0; enable_wreg_om = 0; enable_wreg_ow = 0;
    mem_to_reg_oe = 0; mem_to_reg_om = 0;
    branch_id = 0; pc_src_id = 0;
    muldiv_start_oe = 0; muldiv_id = 0; mfhilo_id = 0;
  endtask

  task automatic chk_stall(input string nm, input logic exp);
    chk({nm, ".stall_if"}, 8'(stall_if), 8'(exp));
    chk({nm, ".stall_id"}, 8'(stall_id), 8'(exp));
    chk({nm, ".flush_oe"}, 8'(flush_oe), 8'(exp));
  endtask

  task automatic add(input string n,
                     input logic [4:0] rs_id, rt_id, rs_oe, rt_oe, wr_oe, wr_om, wr_ow,
                     input logic en_oe, en_om, en_ow, m2r_oe, m2r_om, br, pcsrc,
                     input logic [1:0] fa, fb,
                     input logic fida, fidb, st, fl);
    vec_t v;
    v.name = n; v.rs_id = rs_id; v.rt_id = rt_id; v.rs_oe = rs_oe; v.rt_oe = rt_oe;
    v.wr_oe = wr_oe; v.wr_om = wr_om; v.wr_ow = wr_ow;
    v.en_oe = en_oe; v.en_om = en_om; v.en_ow = en_ow;
    v.m2r_oe = m2r_oe; v.m2r_om = m2r_om; v.br = br; v.pcsrc = pcsrc;
    v.exp_fa = fa; v.exp_fb = fb; v.exp_fida = fida; v.exp_fidb = fidb;
    v.exp_stall = st; v.exp_flush_id = fl;
    vecs.push_back(v);
  endtask

  // One full busy period with mfhilo_id held; a second start mid-run must be ignored.
  task automatic run_busy_period(input string nm);
    mfhilo_id = 1;
    #1;
    chk({nm, ".idle_busy"}, 8'(muldiv_busy), 8'd0);
    chk_stall({nm, ".idle"}, 1'b0);
    muldiv_start_oe = 1;
    @(posedge clk_i); #1;
    muldiv_start_oe = 0;
    for (int k = 0; k < int'(MD); k++) begin
      // k==1: ignored restart; k==2: no HI/LO consumer so no stall; k==3: muldiv_id
      muldiv_start_oe = (k == 1);
      mfhilo_id       = (k != 2) && (k != 3);
      muldiv_id       = (k == 3);
      #1;
      chk($sformatf("%s.busy%0d", nm, k), 8'(muldiv_busy), 8'd1);
      chk_stall($sformatf("%s.st%0d", nm, k), (k != 2));
      @(posedge clk_i); #1;
      muldiv_start_oe = 0;
    end
    mfhilo_id = 1; muldiv_id = 0;
    #1;
    chk({nm, ".done_busy"}, 8'(muldiv_busy), 8'd0);
    chk_stall({nm, ".done"}, 1'b0);
    mfhilo_id = 0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    clear_inputs();
    reset_ni = 0;

    //   name        rsid rtid rsoe rtoe wroe wrom wrow eoe eom eow mroe mrom br pc  fa     fb     fida fidb st fl
    add("zero",        0,  0,   0,   0,   0,   0,   0,  0,  0,  0,  0,   0,  0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    add("mem_over_wb", 0,  0,   5,   0,   0,   5,   5,  0,  1,  1,  0,   0,  0, 0, 2'b10, 2'b00, 0, 0, 0, 0);
    add("r0_nofwd",    0,  0,   0,   0,   0,   0,   0,  0,  1,  1,  0,   0,  0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    add("wb_when_om0", 0,  0,   5,   0,   0,   0,   5,  0,  1,  1,  0,   0,  0, 0, 2'b01, 2'b00, 0, 0, 0, 0);
    add("wb_b",        0,  0,   0,   7,   0,   0,   7,  0,  0,  1,  0,   0,  0, 0, 2'b00, 2'b01, 0, 0, 0, 0);
    add("mix_ab",      0,  0,   3,   4,   0,   3,   4,  0,  1,  1,  0,   0,  0, 0, 2'b10, 2'b01, 0, 0, 0, 0);
    add("en_off",      0,  0,   6,   6,   0,   6,   6,  0,  0,  0,  0,   0,  0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    add("id_fwd",      9,  9,   0,   0,   0,   9,   0,  0,  1,  0,  0,   0,  0, 0, 2'b00, 2'b00, 1, 1, 0, 0);
    add("lw_rs",       3,  0,   0,   0,   3,   0,   0,  1,  0,  0,  1,   0,  0, 1, 2'b00, 2'b00, 0, 0, 1, 0);
    add("lw_r0",       0,  0,   0,   0,   0,   0,   0,  1,  0,  0,  1,   0,  0, 1, 2'b00, 2'b00, 0, 0, 0, 1);
    add("br_ex_alu",   0,  4,   0,   0,   4,   0,   0,  1,  0,  0,  0,   0,  1, 1, 2'b00, 2'b00, 0, 0, 1, 0);
    add("br_nohaz",    5,  6,   0,   0,   4,   0,   0,  1,  0,  0,  0,   0,  1, 1, 2'b00, 2'b00, 0, 0, 0, 1);
    add("br_mem_lw",   8,  0,   0,   0,   0,   8,   0,  0,  0,  0,  0,   1,  1, 0, 2'b00, 2'b00, 0, 0, 1, 0);
    add("alu_nobr",    4,  0,   0,   0,   4,   0,   0,  1,  0,  0,  0,   0,  0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    add("taken",       0,  0,   0,   0,   0,   0,   0,  0,  0,  0,  0,   0,  0, 1, 2'b00, 2'b00, 0, 0, 0, 1);

    // Reset state, including a start pulse across an edge while in reset
    muldiv_start_oe = 1; mfhilo_id = 1;
    @(posedge clk_i); #1;
    chk("rst.busy", 8'(muldiv_busy), 8'd0);
    chk_stall("rst", 1'b0);
    clear_inputs();
    @(negedge clk_i);
    reset_ni = 1;
    @(posedge clk_i); #1;
    chk("post_rst.busy", 8'(muldiv_busy), 8'd0);

    // Combinational table with FSM idle
    foreach (vecs[i]) begin
      rs_id5 = vecs[i].rs_id; rt_id5 = vecs[i].rt_id;
      rs_oe5 = vecs[i].rs_oe; rt_oe5 = vecs[i].rt_oe;
      write_reg_oe5 = vecs[i].wr_oe; write_reg_om5 = vecs[i].wr_om; write_reg_ow5 = vecs[i].wr_ow;
      enable_wreg_oe = vecs[i].en_oe; enable_wreg_om = vecs[i].en_om; enable_wreg_ow = vecs[i].en_ow;
      mem_to_reg_oe = vecs[i].m2r_oe; mem_to_reg_om = vecs[i].m2r_om;
      branch_id = vecs[i].br; pc_src_id = vecs[i].pcsrc;
      #1;
      chk({vecs[i].name, ".fa"}, 8'(forward_a_oe2), 8'(vecs[i].exp_fa));
      chk({vecs[i].name, ".fb"}, 8'(forward_b_oe2), 8'(vecs[i].exp_fb));
      chk({vecs[i].name, ".fida"}, 8'(forward_a_id), 8'(vecs[i].exp_fida));
      chk({vecs[i].name, ".fidb"}, 8'(forward_b_id), 8'(vecs[i].exp_fidb));
      chk_stall(vecs[i].name, vecs[i].exp_stall);
      chk({vecs[i].name, ".flush_id"}, 8'(flush_id), 8'(vecs[i].exp_flush_id));
    end
    clear_inputs();

    // Load-use: stall one cycle, then forward from MEM
    @(posedge clk_i); #1;
    mem_to_reg_oe = 1; enable_wreg_oe = 1; write_reg_oe5 = 3; rt_id5 = 3;
    #1;
    chk_stall("lu.c0", 1'b1);
    @(posedge clk_i); #1;
    mem_to_reg_oe = 0; enable_wreg_oe = 0; write_reg_oe5 = 0; rt_id5 = 0;
    mem_to_reg_om = 1; enable_wreg_om = 1; write_reg_om5 = 3; rt_oe5 = 3;
    #1;
    chk("lu.c1.fb", 8'(forward_b_oe2), 8'b10);
    chk_stall("lu.c1", 1'b0);
    clear_inputs();

    // Branch on EX ALU result: stall without flush, then flush with ID forward
    @(posedge clk_i); #1;
    branch_id = 1; pc_src_id = 1; rs_id5 = 4; enable_wreg_oe = 1; write_reg_oe5 = 4;
    #1;
    chk_stall("br.c0", 1'b1);
    chk("br.c0.flush_id", 8'(flush_id), 8'd0);
    @(posedge clk_i); #1;
    enable_wreg_oe = 0; write_reg_oe5 = 0; enable_wreg_om = 1; write_reg_om5 = 4;
    #1;
    chk_stall("br.c1", 1'b0);
    chk("br.c1.flush_id", 8'(flush_id), 8'd1);
    chk("br.c1.fida", 8'(forward_a_id), 8'd1);
    clear_inputs();

    // Mult/div busy window
    @(posedge clk_i); #1;
    run_busy_period("md1");

    // Async reset mid-BUSY at counter 2
    @(posedge clk_i); #1;
    mfhilo_id = 1; muldiv_start_oe = 1;
    @(posedge clk_i); #1;
    muldiv_start_oe = 0;
    @(posedge clk_i); #1;
    chk("ar.pre.busy", 8'(muldiv_busy), 8'd1);
    chk_stall("ar.pre", 1'b1);
    #2 reset_ni = 0;
    #1;
    chk("ar.in.busy", 8'(muldiv_busy), 8'd0);
    chk_stall("ar.in", 1'b0);
    @(posedge clk_i); #1;
    reset_ni = 1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk_i); #1;
      chk($sformatf("ar.after%0d.busy", k), 8'(muldiv_busy), 8'd0);
      chk_stall($sformatf("ar.after%0d", k), 1'b0);
    end
    mfhilo_id = 0;

    // Fresh start after reset gets a full period
    run_busy_period("md2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
